sha256_msg_padder: RTL and testbench
====================================

# sha256_msg_padder

Upstream front end for the SHA-256 compression core. On `start`, reads `NUM_OF_WORDS` 32-bit message words from memory starting at `message_addr`. Applies standard SHA-256 padding (0x80000000 marker word, zero fill, 64-bit bit-length). Hands the core one complete 512-bit block at a time over a valid/ready handshake, so the core never touches memory or computes padding.

## Interface
- `NUM_OF_WORDS`, default 20: message length in 32-bit words; legal range 1..2000.
- `clk`  in  1: single clock; also forwarded as `mem_clk`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a message; sampled only in IDLE.
- `message_addr`  in  16: word address of message word 0; captured on accepted `start`.
- `mem_clk`  out  1: equals `clk`.
- `mem_we`  out  1: constant 0 (read-only client).
- `mem_addr`  out  16: registered read address.
- `mem_read_data`  in  32: synchronous-read data; valid the cycle after `mem_addr` is presented.
- `blk_valid`  out  1: `blk_data` holds a complete padded block.
- `blk_ready`  in  1: core accepts the block when high with `blk_valid`.
- `blk_data`  out  512: padded block; word k at `[32*k +: 32]`, k = 0..15.
- `blk_last`  out  1: current block is the final block of the message.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the last block is accepted.

## Operation
- Block count NB = (NUM_OF_WORDS + 18) / 16, integer division. This equals ceil((N+3)/16).
- Message bit length L = NUM_OF_WORDS*32, held as 64 bits.
- Global word index g = 16*b + k, for block b and word k. Padded word value:
  - g < N: memory word g.
  - g == N: 0x80000000.
  - b == NB-1, k == 14: L[63:32].
  - b == NB-1, k == 15: L[31:0].
  - otherwise: 0.
- Words fetched for block b: m_b = clamp(N - 16*b, 0, 16).
- States:
  - IDLE: `start` latches the address base, sets b=0, drives `mem_addr` = `message_addr`, and goes to FETCH.
  - FETCH: lasts m_b + 1 cycles.
    - Cycles 0..m_b-1 issue addresses `message_addr` + 16*b + k.
    - Cycles 1..m_b capture `mem_read_data` into buffer word k-1.
    - Non-data words are written with padding values during FETCH. Then go to OUT.
  - OUT: `blk_valid` = 1; `blk_last` = (b == NB-1).
    - On `blk_valid && blk_ready`: if not last, b++ and go to FETCH, with `mem_addr` set to the next block's first address on the same edge.
    - If last: go to IDLE and pulse `done`.
- `blk_data` and `blk_last` are stable while `blk_valid` is high and `blk_ready` is low.
- `start` is ignored outside IDLE.
- `blk_ready` is ignored outside OUT.
- Address arithmetic is 16-bit and wraps modulo 2^16.

## Timing
- Reset values: `blk_valid`=0, `blk_last`=0, `blk_data`=0, `busy`=0, `done`=0, `mem_addr`=0, `mem_we`=0; state is IDLE.
- Reset asserted mid-message returns to IDLE immediately and discards the partial block. No `done` pulse.
- Let E be the edge that samples `start`. `busy` rises after E. `blk_valid` rises m_0+2 cycles after E. For N=20 this is 18 cycles.
- After an accepting edge for a non-last block, the next `blk_valid` rises m_{b+1}+2 cycles later. This is 2 cycles for a padding-only block.
- `done` is high for exactly the cycle after the last accepting edge. `busy` is low in that same cycle.
- A new `start` is accepted in the cycle `done` is high.

## Configuration
- `SHA256_PAD_BSWAP_EN` defined: each memory word is byte-reversed before it enters the block buffer. This serves byte-little-endian message memory. Padding and length words are never swapped.
- Undefined: memory words pass through unchanged.

## Test plan
- N=20, memory word i = i+1, `blk_ready` held 1:
  - block 0 = words 1..16, `blk_last`=0;
  - block 1 = 17,18,19,20, 0x80000000, zeros, word14=0, word15=0x00000280, `blk_last`=1;
  - `done` pulses once;
  - first `blk_valid` 18 cycles after the start edge.
- N=13: single block; word13=0x80000000, word14=0, word15=0x000001A0; `blk_last`=1.
- N=14: block 0 has word14=0x80000000 and word15=0. Block 1 is all zero except word15=0x000001C0, with `blk_valid` 2 cycles after block 0 is accepted.
- N=16 with `blk_ready` low for 10 cycles in each OUT: `blk_data` stable throughout. Block 1 word0=0x80000000, word15=0x00000200. No memory reads are issued for block 1.
- `reset_n` pulsed low during FETCH of block 1: all outputs return to reset values. A subsequent `start` with `message_addr`=0xFFF8 reproduces correct blocks, with addresses wrapping through 0x0000.
- `SHA256_PAD_BSWAP_EN` defined, word0=0x11223344: block word0=0x44332211; length word unchanged.

Source files
------------

// File: rtl/sha256_msg_padder_if.sv
// Block handshake between the SHA-256 message padder (master) and the compression core (slave).
interface sha256_msg_padder_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    modport master (output blk_valid, output blk_data, output blk_last, input blk_ready);
    modport slave  (input blk_valid, input blk_data, input blk_last, output blk_ready);
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: fetches NUM_OF_WORDS words, pads, hands out 512-bit blocks.
// Optional SHA256_PAD_BSWAP_EN byte-reverses each memory word before it enters the block.
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [15:0]                 message_addr,
    output logic                        mem_clk,
    output logic                        mem_we,
    output logic [15:0]                 mem_addr,
    input  logic [31:0]                 mem_read_data,
    sha256_msg_padder_if.master         blk,
    output logic                        busy,
    output logic                        done
);

    localparam int          NW     = NUM_OF_WORDS;
    localparam int          NB     = (NW + 18) / 16;
    localparam logic [7:0]  LAST_B = 8'(NB - 1);
    localparam logic [63:0] LEN    = 64'(NW) * 64'd32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [7:0]   b_q, b_d;
    logic [4:0]   c_q, c_d;
    logic [15:0]  base_q, base_d;
    logic [15:0]  addr_q, addr_d;
    logic [511:0] buf_q, buf_d;
    logic         done_q, done_d;

    logic         is_last;
    logic [4:0]   m_b;
    int           rem;
    logic [511:0] pad_blk;
    logic [31:0]  mem_word;

    assign is_last = (b_q == LAST_B);

`ifdef SHA256_PAD_BSWAP_EN
    assign mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                       mem_read_data[23:16], mem_read_data[31:24]};
`else
    assign mem_word = mem_read_data;
`endif

    // Number of memory words that belong to the current block.
    always_comb begin
        rem = NW - 16 * int'(b_q);
        if (rem <= 0) begin
            m_b = 5'd0;
        end else if (rem >= 16) begin
            m_b = 5'd16;
        end else begin
            m_b = 5'(rem);
        end
    end

    always_comb begin
        int          g;
        logic [31:0] w;
        g       = 0;
        w       = '0;
        pad_blk = buf_q;
        for (int unsigned k = 0; k < 16; k++) begin
            if (k >= 32'(m_b)) begin
                g = 16 * int'(b_q) + int'(k);
                if (g == NW) begin
                    w = 32'h8000_0000;
                end else if (is_last && k == 14) begin
                    w = LEN[63:32];
                end else if (is_last && k == 15) begin
                    w = LEN[31:0];
                end else begin
                    w = '0;
                end
                pad_blk[32*k +: 32] = w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        c_d     = c_q;
        base_d  = base_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = message_addr;
                    addr_d  = message_addr;
                    b_d     = '0;
                    c_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Cycle 0 lays down padding; data words arrive one cycle behind their address.
                if (c_q == 5'd0) begin
                    buf_d = pad_blk;
                end else begin
                    buf_d[32*(int'(c_q) - 1) +: 32] = mem_word;
                end
                if ((6'(c_q) + 6'd1) < 6'(m_b)) begin
                    addr_d = addr_q + 16'd1;
                end
                if (c_q == m_b) begin
                    state_d = OUT;
                end else begin
                    c_d = c_q + 5'd1;
                end
            end
            OUT: begin
                if (blk.blk_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        b_d     = b_q + 8'd1;
                        c_d     = '0;
                        addr_d  = base_q + 16'({b_q + 8'd1, 4'b0000});
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            c_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            c_q     <= c_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    assign mem_clk       = clk;
    assign mem_we        = 1'b0;
    assign mem_addr      = addr_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign blk.blk_valid = (state_q == OUT);
    assign blk.blk_last  = (state_q == OUT) && is_last;
    assign blk.blk_data  = buf_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: four instances (N=20,13,14,16) sharing one memory.
module tb_sha256_msg_padder;

    typedef struct {
        int           inst;
        logic [511:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  mem [65536];
    logic [15:0]  addr_in = '0;
    logic         start_s [4];
    logic         ready_s [4];
    logic         valid_s [4];
    logic         last_s  [4];
    logic [511:0] data_s  [4];
    logic         busy_s  [4];
    logic         done_s  [4];
    logic         we_s    [4];
    logic         mclk_s  [4];
    logic [15:0]  maddr_s [4];
    int           done_cnt_s [4];

    exp_t         exp_q [$];
    logic [511:0] got [8];
    int           n_checks = 0;
    int           n_errs = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input int i);
        case (i)
            0: n_of = 20;
            1: n_of = 13;
            2: n_of = 14;
            default: n_of = 16;
        endcase
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SHA256_PAD_BSWAP_EN
        sw = {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        sw = x;
`endif
    endfunction

    function automatic logic [511:0] model_blk(input int n, input int b, input logic [15:0] base);
        int           nb;
        int           g;
        logic [63:0]  len;
        logic [15:0]  a;
        logic [31:0]  w;
        nb  = (n + 18) / 16;
        len = 64'(n) * 64'd32;
        model_blk = '0;
        for (int k = 0; k < 16; k++) begin
            g = 16 * b + k;
            a = base + 16'(g);
            if (g < n)                         w = sw(mem[a]);
            else if (g == n)                   w = 32'h8000_0000;
            else if (b == nb - 1 && k == 14)   w = len[63:32];
            else if (b == nb - 1 && k == 15)   w = len[31:0];
            else                               w = '0;
            model_blk[32*k +: 32] = w;
        end
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int NW = n_of(i);
        sha256_msg_padder_if u_if ();
        logic [15:0] maddr;
        logic [31:0] rdata;
        logic        held = 1'b0;
        logic [511:0] ref_data;
        logic        ref_last;
        int          dcnt = 0;
        exp_t        e;

        sha256_msg_padder #(.NUM_OF_WORDS(NW)) u_dut (
            .clk           (clk),
            .reset_n       (rst_n),
            .start         (start_s[i]),
            .message_addr  (addr_in),
            .mem_clk       (mclk_s[i]),
            .mem_we        (we_s[i]),
            .mem_addr      (maddr),
            .mem_read_data (rdata),
            .blk           (u_if.master),
            .busy          (busy_s[i]),
            .done          (done_s[i])
        );

        always @(posedge clk) rdata <= mem[maddr];

        assign u_if.blk_ready = ready_s[i];
        assign valid_s[i]     = u_if.blk_valid;
        assign last_s[i]      = u_if.blk_last;
        assign data_s[i]      = u_if.blk_data;
        assign maddr_s[i]     = maddr;
        assign done_cnt_s[i]  = dcnt;

        always @(negedge clk) begin
            if (rst_n && u_if.blk_valid) begin
                if (held) begin
                    chk("stable_data", u_if.blk_data, ref_data);
                    chk("stable_last", 512'(u_if.blk_last), 512'(ref_last));
                end
                if (ready_s[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_empty", 512'(1), 512'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_inst", 512'(i), 512'(e.inst));
                        chk("blk_data", u_if.blk_data, e.data);
                        chk("blk_last", 512'(u_if.blk_last), 512'(e.last));
                    end
                    held = 1'b0;
                end else if (!held) begin
                    ref_data = u_if.blk_data;
                    ref_last = u_if.blk_last;
                    held     = 1'b1;
                end
            end else begin
                held = 1'b0;
            end
            if (rst_n && done_s[i]) dcnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] base, input int n, input logic [31:0] seed);
        for (int k = 0; k < n; k++) mem[base + 16'(k)] = seed + 32'(k);
    endtask

    task automatic push_msg(input int i, input logic [15:0] base, input int nblk);
        int nb;
        exp_t e;
        nb = (n_of(i) + 18) / 16;
        for (int b = 0; b < nblk; b++) begin
            e.inst = i;
            e.data = model_blk(n_of(i), b, base);
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_msg(input int i, input logic [15:0] base, input int stall);
        int n, nb, m, cyc, d0;
        n  = n_of(i);
        nb = (n + 18) / 16;
        push_msg(i, base, nb);
        d0 = done_cnt_s[i];
        ready_s[i] = (stall == 0);
        addr_in    = base;
        start_s[i] = 1'b1;
        tick();
        start_s[i] = 1'b0;
        chk("busy_rise", 512'(busy_s[i]), 512'(1));
        for (int b = 0; b < nb; b++) begin
            m = n - 16 * b;
            if (m < 0) m = 0;
            if (m > 16) m = 16;
            cyc = 1;
            while (!valid_s[i] && cyc < 200) begin
                tick();
                cyc++;
            end
            chk("valid_latency", 512'(cyc), 512'(m + 2));
            got[b] = data_s[i];
            if (stall > 0) begin
                repeat (stall) tick();
                ready_s[i] = 1'b1;
                tick();
                ready_s[i] = 1'b0;
            end else begin
                tick();
            end
            if (b == nb - 1) begin
                chk("done_pulse", 512'(done_s[i]), 512'(1));
                chk("busy_at_done", 512'(busy_s[i]), 512'(0));
                tick();
                chk("done_fall", 512'(done_s[i]), 512'(0));
            end
        end
        chk("done_count", 512'(done_cnt_s[i] - d0), 512'(1));
        ready_s[i] = 1'b0;
    endtask

    initial begin
        int d0, cyc;
        for (int i = 0; i < 4; i++) begin
            start_s[i] = 1'b0;
            ready_s[i] = 1'b0;
        end
        for (int a = 0; a < 65536; a++) mem[a] = 32'hDEAD_0000 | 32'(a);
        tick();
        tick();
        chk("rst_valid", 512'(valid_s[0]), 512'(0));
        chk("rst_last",  512'(last_s[0]),  512'(0));
        chk("rst_data",  data_s[0], '0);
        chk("rst_busy",  512'(busy_s[0]),  512'(0));
        chk("rst_done",  512'(done_s[0]),  512'(0));
        chk("rst_addr",  512'(maddr_s[0]), 512'(0));
        chk("mem_we",    512'(we_s[0]),    512'(0));
        rst_n = 1'b1;
        tick();
        chk("mem_clk", 512'(mclk_s[0]), 512'(clk));

        // N=20, memory word i = i+1
        fill(16'h0100, 20, 32'd1);
        run_msg(0, 16'h0100, 0);
        chk("n20_b0w0",  512'(got[0][31:0]),     512'(sw(32'd1)));
        chk("n20_b0w15", 512'(got[0][511:480]),  512'(sw(32'd16)));
        chk("n20_b1w4",  512'(got[1][128 +: 32]), 512'(32'h8000_0000));
        chk("n20_b1w14", 512'(got[1][448 +: 32]), 512'(0));
        chk("n20_b1w15", 512'(got[1][511:480]),  512'(32'h0000_0280));

        // N=13: single block
        fill(16'h0200, 13, 32'd1);
        run_msg(1, 16'h0200, 0);
        chk("n13_w13", 512'(got[0][416 +: 32]), 512'(32'h8000_0000));
        chk("n13_w15", 512'(got[0][511:480]),   512'(32'h0000_01A0));

        // N=14: marker in block 0, length alone in block 1
        fill(16'h0300, 14, 32'd1);
        run_msg(2, 16'h0300, 0);
        chk("n14_b0w14", 512'(got[0][448 +: 32]), 512'(32'h8000_0000));
        chk("n14_b0w15", 512'(got[0][511:480]),   512'(0));
        chk("n14_b1",    got[1], {32'h0000_01C0, 480'd0});

        // N=16 with back-pressure
        fill(16'h0400, 16, 32'd1);
        run_msg(3, 16'h0400, 10);
        chk("n16_b1w0",  512'(got[1][31:0]),    512'(32'h8000_0000));
        chk("n16_b1w15", 512'(got[1][511:480]), 512'(32'h0000_0200));

        // Reset during FETCH of block 1
        fill(16'h0500, 20, 32'd7);
        push_msg(0, 16'h0500, 1);
        d0 = done_cnt_s[0];
        ready_s[0] = 1'b1;
        addr_in    = 16'h0500;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        cyc = 1;
        while (!valid_s[0] && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rst_run_latency", 512'(cyc), 512'(18));
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 512'(valid_s[0]), 512'(0));
        chk("midrst_last",  512'(last_s[0]),  512'(0));
        chk("midrst_data",  data_s[0], '0);
        chk("midrst_busy",  512'(busy_s[0]),  512'(0));
        chk("midrst_done",  512'(done_s[0]),  512'(0));
        chk("midrst_addr",  512'(maddr_s[0]), 512'(0));
        chk("sb_drained",   512'(exp_q.size()), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("no_done_after_rst", 512'(done_cnt_s[0] - d0), 512'(0));
        ready_s[0] = 1'b0;

        // Address wrap through 0x0000
        fill(16'hFFF8, 20, 32'hC0DE_0000);
        run_msg(0, 16'hFFF8, 0);
        chk("wrap_w7", 512'(got[0][224 +: 32]), 512'(sw(32'hC0DE_0007)));
        chk("wrap_w8", 512'(got[0][256 +: 32]), 512'(sw(32'hC0DE_0008)));

        // Byte order of memory words
        fill(16'h0040, 13, 32'h1122_3344);
        run_msg(1, 16'h0040, 0);
`ifdef SHA256_PAD_BSWAP_EN
        chk("bswap_w0", 512'(got[0][31:0]), 512'(32'h4433_2211));
`else
        chk("bswap_w0", 512'(got[0][31:0]), 512'(32'h1122_3344));
`endif
        chk("bswap_len", 512'(got[0][511:480]), 512'(32'h0000_01A0));
        chk("sb_final", 512'(exp_q.size()), 512'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
